// File: rtl/io_port_bridge_if.sv
// Port-side bundle between the core's IN/OUT ports, the bridge and the external byte device.
// The slave view is the bridge; the master view is whatever drives the core/device side.
interface io_port_bridge_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] Out_Port;
   logic             out_wr;
   logic [WIDTH-1:0] IN_Port;
   logic             in_rd;
   logic             Interrupt;
   logic [WIDTH-1:0] dev_rx_data;
   logic             dev_rx_valid;
   logic             dev_rx_ready;
   logic [WIDTH-1:0] dev_tx_data;
   logic             dev_tx_valid;
   logic             dev_tx_ready;
   logic             tx_full;
   logic             tx_overflow;

   modport slave (
      input  Out_Port, out_wr, in_rd, dev_rx_data, dev_rx_valid, dev_tx_ready,
      output IN_Port, Interrupt, dev_rx_ready, dev_tx_data, dev_tx_valid, tx_full, tx_overflow
   );

   modport master (
      output Out_Port, out_wr, in_rd, dev_rx_data, dev_rx_valid, dev_tx_ready,
      input  IN_Port, Interrupt, dev_rx_ready, dev_tx_data, dev_tx_valid, tx_full, tx_overflow
   );
endinterface

// File: rtl/io_port_bridge.sv
// Port-side I/O bridge: RX FIFO (device -> core, with one interrupt pulse per byte)
// and TX FIFO (core -> device, with sticky overflow flag).
module io_port_bridge #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   io_port_bridge_if.slave bus_io
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   typedef enum logic {ST_IDLE, ST_PENDING} irq_state_t;

   logic [WIDTH-1:0] rx_mem_q [DEPTH];
   logic [AW-1:0]    rx_wptr_q, rx_rptr_q;
   logic [CW-1:0]    rx_count_q;
   logic [WIDTH-1:0] tx_mem_q [DEPTH];
   logic [AW-1:0]    tx_wptr_q, tx_rptr_q;
   logic [CW-1:0]    tx_count_q;
   logic             tx_overflow_q;
   irq_state_t       state_q, state_d;
   logic             irq_q, irq_d;

   logic rx_full, rx_empty, rx_push, rx_pop;
   logic tx_full_w, tx_empty, tx_push, tx_pop;

   assign rx_full  = (rx_count_q == FULL_CNT);
   assign rx_empty = (rx_count_q == '0);
   assign tx_full_w = (tx_count_q == FULL_CNT);
   assign tx_empty = (tx_count_q == '0);

   // Ready is based on the registered count alone, so a full RX never accepts during a pop.
   assign rx_push = bus_io.dev_rx_valid & ~rx_full;
   assign rx_pop  = bus_io.in_rd & ~rx_empty;
   assign tx_pop  = ~tx_empty & bus_io.dev_tx_ready;
   assign tx_push = bus_io.out_wr & (~tx_full_w | tx_pop);

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wptr_q] <= bus_io.dev_rx_data;
      if (tx_push) tx_mem_q[tx_wptr_q] <= bus_io.Out_Port;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wptr_q  <= '0;
         rx_rptr_q  <= '0;
         rx_count_q <= '0;
      end else begin
         if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count_q <= rx_count_q + CW'(1);
            2'b01:   rx_count_q <= rx_count_q - CW'(1);
            default: rx_count_q <= rx_count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wptr_q     <= '0;
         tx_rptr_q     <= '0;
         tx_count_q    <= '0;
         tx_overflow_q <= 1'b0;
      end else begin
         if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count_q <= tx_count_q + CW'(1);
            2'b01:   tx_count_q <= tx_count_q - CW'(1);
            default: tx_count_q <= tx_count_q;
         endcase
         if (bus_io.out_wr & ~tx_push) tx_overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         irq_q   <= irq_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (!rx_empty) state_d = ST_PENDING;
         ST_PENDING: if (rx_pop)    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Re-armed only by a pop, so each byte yields exactly one pulse.
   always_comb begin
      irq_d = (state_q == ST_IDLE) && !rx_empty;
   end

   assign bus_io.IN_Port      = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
   assign bus_io.Interrupt    = irq_q;
   assign bus_io.dev_rx_ready = ~rx_full;
   assign bus_io.dev_tx_data  = tx_mem_q[tx_rptr_q];
   assign bus_io.dev_tx_valid = ~tx_empty;
   assign bus_io.tx_full      = tx_full_w;
   assign bus_io.tx_overflow  = tx_overflow_q;
endmodule

// File: tb/tb_io_port_bridge.sv
// Directed plus randomized checking of io_port_bridge against a queue-based reference model.
module tb_io_port_bridge;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   io_port_bridge_if #(.WIDTH(8)) bus ();
   io_port_bridge #(.DEPTH(DEPTH), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus_io(bus));

   int n_chk = 0, n_pass = 0, n_fail = 0;
   logic [7:0] rx_q[$], tx_q[$], in_got[$], dev_got[$];
   bit m_ovf = 0, m_armed = 1, m_int = 0;
   bit last_rx_push = 0;
   int pulses = 0;
   bit int_seen = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("in_port", bus.IN_Port, (rx_q.size() != 0) ? rx_q[0] : 8'h00);
      chk("interrupt", 8'(bus.Interrupt), 8'(m_int));
      chk("dev_rx_ready", 8'(bus.dev_rx_ready), 8'(rx_q.size() < DEPTH));
      chk("dev_tx_valid", 8'(bus.dev_tx_valid), 8'(tx_q.size() != 0));
      chk("tx_full", 8'(bus.tx_full), 8'(tx_q.size() == DEPTH));
      chk("tx_overflow", 8'(bus.tx_overflow), 8'(m_ovf));
      if (tx_q.size() != 0) chk("dev_tx_data", bus.dev_tx_data, tx_q[0]);
   endtask

   // One clock: apply the spec's push/pop/interrupt rules to the model, then compare.
   task automatic cycle();
      bit rx_push, rx_pop, tx_push, tx_pop, nxt_int;
      logic [7:0] rx_head_obs, tx_head_obs;
      rx_head_obs = bus.IN_Port;
      tx_head_obs = bus.dev_tx_data;
      @(posedge clk);
      if (rst) begin
         rx_q.delete();
         tx_q.delete();
         m_ovf = 0; m_armed = 1; m_int = 0; last_rx_push = 0;
      end else begin
         rx_push = bus.dev_rx_valid && (rx_q.size() < DEPTH);
         rx_pop  = bus.in_rd && (rx_q.size() != 0);
         tx_pop  = bus.dev_tx_ready && (tx_q.size() != 0);
         tx_push = bus.out_wr && ((tx_q.size() < DEPTH) || tx_pop);
         nxt_int = m_armed && (rx_q.size() != 0);
         if (nxt_int) m_armed = 0;
         else if (rx_pop) m_armed = 1;
         m_int = nxt_int;
         if (bus.out_wr && !tx_push) m_ovf = 1;
         if (rx_pop) begin in_got.push_back(rx_head_obs); void'(rx_q.pop_front()); end
         if (rx_push) rx_q.push_back(bus.dev_rx_data);
         if (tx_pop) begin dev_got.push_back(tx_head_obs); void'(tx_q.pop_front()); end
         if (tx_push) tx_q.push_back(bus.Out_Port);
         last_rx_push = rx_push;
      end
      #1;
      if (bus.Interrupt) begin pulses++; int_seen = 1; end
      check_outputs();
   endtask

   task automatic idle_inputs();
      bus.Out_Port = 8'h00; bus.out_wr = 1'b0; bus.in_rd = 1'b0;
      bus.dev_rx_data = 8'h00; bus.dev_rx_valid = 1'b0; bus.dev_tx_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_tx [5];
      int idx;
      exp_tx = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB7};
      idle_inputs();

      // Power-on reset
      cycle(); cycle();
      rst = 1'b0;
      repeat (2) cycle();

      // Single RX byte
      bus.dev_rx_data = 8'h55; bus.dev_rx_valid = 1'b1;
      cycle();
      bus.dev_rx_valid = 1'b0;
      chk("single_in_port", bus.IN_Port, 8'h55);
      chk("single_irq_n", 8'(bus.Interrupt), 8'h00);
      cycle();
      chk("single_irq_n1", 8'(bus.Interrupt), 8'h01);
      cycle();
      chk("single_irq_n2", 8'(bus.Interrupt), 8'h00);
      cycle();
      bus.in_rd = 1'b1;
      cycle();
      bus.in_rd = 1'b0;
      pulses = 0;
      repeat (3) cycle();
      chk("single_after_pop", bus.IN_Port, 8'h00);
      chk("single_no_repulse", 8'(pulses), 8'h00);

      // Empty pop
      bus.in_rd = 1'b1;
      cycle();
      bus.in_rd = 1'b0;
      cycle();
      chk("empty_pop_in_port", bus.IN_Port, 8'h00);
      chk("empty_pop_ready", 8'(bus.dev_rx_ready), 8'h01);

      // RX burst and fill
      pulses = 0; int_seen = 0; in_got.delete();
      for (int i = 0; i < 4; i++) begin
         bus.dev_rx_data = 8'((i + 1) * 17); bus.dev_rx_valid = 1'b1;
         cycle();
      end
      chk("burst_ready_low", 8'(bus.dev_rx_ready), 8'h00);
      bus.dev_rx_data = 8'h99;
      repeat (3) cycle();
      bus.dev_rx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         for (int w = 0; w < 10 && !int_seen; w++) cycle();
         chk("burst_irq_before_pop", 8'(int_seen), 8'h01);
         int_seen = 0;
         bus.in_rd = 1'b1;
         cycle();
         bus.in_rd = 1'b0;
      end
      repeat (4) cycle();
      chk("burst_pulses", 8'(pulses), 8'h04);
      chk("burst_pop_count", 8'(in_got.size()), 8'h04);
      for (int i = 0; i < 4 && i < in_got.size(); i++)
         chk("burst_pop_data", in_got[i], 8'((i + 1) * 17));

      // TX overflow, then simultaneous push/pop while full, then drain
      dev_got.delete();
      bus.dev_tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.Out_Port = 8'(8'hA0 + i); bus.out_wr = 1'b1;
         cycle();
         if (i == 3) chk("ovf_full_after_a3", 8'(bus.tx_full), 8'h01);
      end
      bus.out_wr = 1'b0;
      chk("ovf_flag", 8'(bus.tx_overflow), 8'h01);
      bus.Out_Port = 8'hB7; bus.out_wr = 1'b1; bus.dev_tx_ready = 1'b1;
      cycle();
      bus.out_wr = 1'b0; bus.dev_tx_ready = 1'b0;
      chk("simul_still_full", 8'(bus.tx_full), 8'h01);
      chk("simul_head", bus.dev_tx_data, 8'hA1);
      bus.dev_tx_ready = 1'b1;
      for (int w = 0; w < 20 && bus.dev_tx_valid; w++) cycle();
      bus.dev_tx_ready = 1'b0;
      chk("drain_done", 8'(bus.dev_tx_valid), 8'h00);
      chk("ovf_sticky", 8'(bus.tx_overflow), 8'h01);
      chk("drain_count", 8'(dev_got.size()), 8'h05);
      for (int i = 0; i < 5 && i < dev_got.size(); i++)
         chk("drain_data", dev_got[i], exp_tx[i]);

      // Pointer wrap: 3*DEPTH+1 bytes with random interleaved pops
      in_got.delete();
      idx = 0;
      for (int c = 0; c < 300 && (idx < 3 * DEPTH + 1 || rx_q.size() != 0); c++) begin
         bus.dev_rx_valid = (idx < 3 * DEPTH + 1);
         bus.dev_rx_data = 8'(idx);
         bus.in_rd = 1'($urandom_range(0, 1));
         cycle();
         if (last_rx_push) idx++;
      end
      idle_inputs();
      cycle();
      chk("wrap_all_pushed", 8'(idx), 8'(3 * DEPTH + 1));
      chk("wrap_pop_count", 8'(in_got.size()), 8'(3 * DEPTH + 1));
      for (int i = 0; i < in_got.size(); i++)
         chk("wrap_data", in_got[i], 8'(i));

      // Randomized traffic in both directions
      for (int c = 0; c < 400; c++) begin
         bus.dev_rx_valid = 1'($urandom_range(0, 1));
         bus.dev_rx_data = 8'($urandom);
         bus.in_rd = ($urandom_range(0, 2) == 0);
         bus.out_wr = 1'($urandom_range(0, 1));
         bus.Out_Port = 8'($urandom);
         bus.dev_tx_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      idle_inputs();
      cycle();

      // Asynchronous reset mid-stream with RX=2, TX=3 (drain RX first)
      bus.in_rd = 1'b1;
      for (int w = 0; w < 10 && rx_q.size() != 0; w++) cycle();
      bus.in_rd = 1'b0;
      bus.dev_tx_ready = 1'b1;
      for (int w = 0; w < 10 && tx_q.size() != 0; w++) cycle();
      bus.dev_tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.out_wr = 1'b1; bus.Out_Port = 8'(8'hD1 + i);
         bus.dev_rx_valid = (i < 2); bus.dev_rx_data = 8'(8'hC1 + i);
         cycle();
      end
      idle_inputs();
      chk("pre_rst_rx_count", 8'(rx_q.size()), 8'h02);
      chk("pre_rst_tx_count", 8'(tx_q.size()), 8'h03);
      #2 rst = 1'b1;
      #1;
      chk("rst_in_port", bus.IN_Port, 8'h00);
      chk("rst_interrupt", 8'(bus.Interrupt), 8'h00);
      chk("rst_tx_overflow", 8'(bus.tx_overflow), 8'h00);
      chk("rst_rx_ready", 8'(bus.dev_rx_ready), 8'h01);
      chk("rst_tx_valid", 8'(bus.dev_tx_valid), 8'h00);
      chk("rst_tx_full", 8'(bus.tx_full), 8'h00);
      cycle(); cycle();
      rst = 1'b0;
      pulses = 0;
      repeat (6) cycle();
      chk("post_rst_no_pulse", 8'(pulses), 8'h00);
      chk("post_rst_in_port", bus.IN_Port, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
